// File: rtl/transmitter_block_pkg.sv
// Shared settings for the transmitter block: command encodings, default widths,
// the LFSR polynomial and the burst FSM state type.
package transmitter_block_pkg;

    localparam int ADDR_W_DEF  = 31;
    localparam int DATA_W_DEF  = 128;
    localparam int BURST_W_DEF = 11;
    localparam int PEND_W_DEF  = 16;

    localparam logic TRANS_WRITE = 1'b0;
    localparam logic TRANS_READ  = 1'b1;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE_S,
        WRITE_S,
        READ_S
    } trans_state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_POLY) : (value >> 1);
    endfunction

endpackage

// File: rtl/transmitter_block_if.sv
// Command channel from the control block and the Avalon-MM master channel
// toward the memory under test.
interface trans_cmd_if import transmitter_block_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              trans_valid;
    logic              trans_type;
    logic [ADDR_W-1:0] trans_addr;
    logic              trans_ready;
    logic              trans_busy;

    modport master (output trans_valid, trans_type, trans_addr,
                    input  trans_ready, trans_busy);
    modport slave  (input  trans_valid, trans_type, trans_addr,
                    output trans_ready, trans_busy);
endinterface

interface amm_if import transmitter_block_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [BURST_W-1:0]  burstcount;
    logic                waitrequest;
    logic                readdatavalid;

    modport master (output address, read, write, writedata, byteenable, burstcount,
                    input  waitrequest, readdatavalid);
    modport slave  (input  address, read, write, writedata, byteenable, burstcount,
                    output waitrequest, readdatavalid);
endinterface

// File: rtl/transmitter_block_data_gen.sv
// Write-data source: fixed 32-bit pattern, or a seeded LFSR when
// TRANS_RND_DATA_EN is defined; the word is replicated across the data bus.
module transmitter_block_data_gen import transmitter_block_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [31:0]       seed_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] data_o
);

    logic [31:0] word_reg;

`ifdef TRANS_RND_DATA_EN
    // An all-zero state would lock the LFSR, so a zero seed becomes 1
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_reg <= '0;
        end else if (load_i) begin
            word_reg <= (seed_i == 32'h0) ? 32'h1 : seed_i;
        end else if (advance_i) begin
            word_reg <= lfsr_step(word_reg);
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_reg <= '0;
        end else if (load_i) begin
            word_reg <= seed_i;
        end else if (advance_i) begin
            word_reg <= word_reg;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 32; gi++) begin : g_lane
            assign data_o[gi*32 +: 32] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/transmitter_block.sv
// Turns accepted commands into Avalon-MM bursts and tracks outstanding read beats.
// Optional random write data: define TRANS_RND_DATA_EN.
module transmitter_block import transmitter_block_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF,
    parameter int PEND_W  = PEND_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               test_start_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic [31:0]        data_pattern_i,
    trans_cmd_if.slave         cmd,
    amm_if.master              amm
);

    localparam int SUM_W = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;
    localparam logic [SUM_W-1:0]   PEND_MAX = {{(SUM_W-PEND_W){1'b0}}, {PEND_W{1'b1}}};
    localparam logic [BURST_W-1:0] ONE_BEAT = {{(BURST_W-1){1'b0}}, 1'b1};

    trans_state_t       state_reg, state_next;
    logic [BURST_W-1:0] len_reg;
    logic [BURST_W-1:0] burst_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [BURST_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [PEND_W-1:0]  pending_reg, pending_next;
    logic               ready_reg, ready_next;
    logic               busy_reg, busy_next;
    logic               accept, write_beat, read_done, beat_ret;

    assign accept     = cmd.trans_valid && ready_reg;
    assign write_beat = (state_reg == WRITE_S) && !amm.waitrequest;
    assign read_done  = (state_reg == READ_S) && !amm.waitrequest;
    assign beat_ret   = amm.readdatavalid && (pending_reg != '0);

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE_S: begin
                if (accept) begin
                    if (cmd.trans_type == TRANS_WRITE) begin
                        state_next = WRITE_S;
                    end else if (cmd.trans_type == TRANS_READ) begin
                        state_next = READ_S;
                    end
                end
            end
            WRITE_S: begin
                if (write_beat) begin
                    if (beat_cnt_reg == burst_reg - ONE_BEAT) begin
                        beat_cnt_next = '0;
                        state_next    = IDLE_S;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + ONE_BEAT;
                    end
                end
            end
            READ_S: begin
                if (read_done) begin
                    state_next = IDLE_S;
                end
            end
            default: state_next = IDLE_S;
        endcase

        // A return coinciding with a command completion nets to +burst-1
        pending_next = pending_reg
                     + (read_done ? PEND_W'(burst_reg) : '0)
                     - (beat_ret ? PEND_W'(1) : '0);

        ready_next = (state_next == IDLE_S)
                  && ((SUM_W'(pending_next) + SUM_W'(len_reg)) <= PEND_MAX);
        busy_next  = (state_next != IDLE_S) || (pending_next != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE_S;
            len_reg      <= '0;
            burst_reg    <= '0;
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
            pending_reg  <= '0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            pending_reg  <= pending_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            if (test_start_i) begin
                len_reg <= (burst_len_i == '0) ? ONE_BEAT : burst_len_i;
            end
            if (accept) begin
                burst_reg <= len_reg;
                addr_reg  <= cmd.trans_addr;
            end
        end
    end

    transmitter_block_data_gen #(.DATA_W(DATA_W)) u_data_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (test_start_i),
        .seed_i    (data_pattern_i),
        .advance_i (write_beat),
        .data_o    (amm.writedata)
    );

    assign cmd.trans_ready = ready_reg;
    assign cmd.trans_busy  = busy_reg;
    assign amm.address     = addr_reg;
    assign amm.burstcount  = burst_reg;
    assign amm.write       = (state_reg == WRITE_S);
    assign amm.read        = (state_reg == READ_S);
    assign amm.byteenable  = '1;

endmodule
